fwd_hazard_sb: RTL and testbench

- Parametrised forwarding and hazard unit for the 5-stage MIPS datapath, generalised to N_SRC operand ports per stage.
- Producer readiness is per stage, replacing fixed load/branch decode; operands needed early (in ID, e.g. branch compare) are marked per source.
- Adds a sequential scoreboard for the multi-cycle mul/div unit (HI/LO busy countdown with cancel) and a saturating stall-cycle performance counter.
- Sits between the ID/EX/MM/WB pipeline registers and the ID/EX operand muxes.

---
 rtl/fwd_hazard_sb.sv | 203 ++++++++++++++++++++
 tb/tb_fwd_hazard_sb.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_sb.sv
// Operand forwarding, hazard detection and mul/div scoreboard for the 5-stage pipeline.
// Latency: forward/stall are combinational; md counter, md_done and stall_cycles are registered (1 cycle).
// Backpressure: stall freezes PC/IF/ID and bubbles EX; a stalled mul/div start is not accepted until the stall clears.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   id_valid                      ID holds a real instruction
//   id_src_reg / id_src_early     ID source indices (N_SRC x REG_W) / per-source "consumed in ID" flag
//   ex_src_reg                    EX source indices (N_SRC x REG_W)
//   {ex,mm,wb}_wr_reg/_wr_data    destination index (0 = no write) and result per producer stage
//   ex_wr_ready, mm_wr_ready      the stage's result is final (WB is always final)
//   id_md_start, id_md_cycles     ID launches mul/div with the given latency
//   id_hilo_rd                    ID reads HI/LO
//   md_cancel                     exception flush, aborts the mul/div countdown
//   perf_clr                      synchronous clear of stall_cycles
//   stall                         pipeline freeze request
//   fwd_id_en/_data               forward select and value per ID source
//   fwd_ex_en/_data               forward select and value per EX source
//   md_busy, md_done              countdown non-zero / one-cycle pulse on natural expiry
//   stall_cycles                  saturating count of stalled cycles
module fwd_hazard_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned N_SRC  = 2,
    parameter int unsigned CNT_W  = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      id_valid,
    input  logic [N_SRC*REG_W-1:0]    id_src_reg,
    input  logic [N_SRC-1:0]          id_src_early,
    input  logic [N_SRC*REG_W-1:0]    ex_src_reg,

    input  logic [REG_W-1:0]          ex_wr_reg,
    input  logic [REG_W-1:0]          mm_wr_reg,
    input  logic [REG_W-1:0]          wb_wr_reg,
    input  logic [DATA_W-1:0]         ex_wr_data,
    input  logic [DATA_W-1:0]         mm_wr_data,
    input  logic [DATA_W-1:0]         wb_wr_data,
    input  logic                      ex_wr_ready,
    input  logic                      mm_wr_ready,

    input  logic                      id_md_start,
    input  logic [CNT_W-1:0]          id_md_cycles,
    input  logic                      id_hilo_rd,
    input  logic                      md_cancel,
    input  logic                      perf_clr,

    output logic                      stall,
    output logic [N_SRC-1:0]          fwd_id_en,
    output logic [N_SRC*DATA_W-1:0]   fwd_id_data,
    output logic [N_SRC-1:0]          fwd_ex_en,
    output logic [N_SRC*DATA_W-1:0]   fwd_ex_data,
    output logic                      md_busy,
    output logic                      md_done,
    output logic [31:0]               stall_cycles
);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] md_cnt_q;
    logic [CNT_W-1:0] md_cnt_d;
    logic             md_done_q;
    logic             md_done_d;
    logic [31:0]      stall_cnt_q;
    logic [31:0]      stall_cnt_d;

    logic [N_SRC-1:0] src_haz;
    logic             md_haz;
    logic             md_load;
    logic [CNT_W-1:0] md_load_val;

    // ------------------------------------------------------------------
    // ID-stage forwarding and per-source hazard.
    // The youngest producer (EX) wins, so an older MM/WB copy of the same
    // register can never mask a value still in flight.
    // ------------------------------------------------------------------
    always_comb begin
        logic [REG_W-1:0] src;
        logic             hit_ex;
        logic             hit_mm;
        logic             hit_wb;

        fwd_id_en   = '0;
        fwd_id_data = '0;
        src_haz     = '0;
        src         = '0;
        hit_ex      = 1'b0;
        hit_mm      = 1'b0;
        hit_wb      = 1'b0;

        for (int i = 0; i < int'(N_SRC); i++) begin
            src = id_src_reg[i*REG_W +: REG_W];
            // r0 is hard-wired zero: never a dependency, regardless of wr_reg.
            hit_ex = (src != '0) && (src == ex_wr_reg);
            hit_mm = (src != '0) && (src == mm_wr_reg);
            hit_wb = (src != '0) && (src == wb_wr_reg);

            if (hit_ex) begin
                fwd_id_en[i]                    = 1'b1;
                fwd_id_data[i*DATA_W +: DATA_W] = ex_wr_data;
                // An early consumer needs the value this cycle, but EX results
                // only become available at the end of EX: always wait.
                src_haz[i] = id_src_early[i] | ~ex_wr_ready;
            end else if (hit_mm) begin
                fwd_id_en[i]                    = 1'b1;
                fwd_id_data[i*DATA_W +: DATA_W] = mm_wr_data;
                // A normal source reaches EX one cycle later, by which time
                // the MM result has moved to WB and is final; only an early
                // consumer can observe an unfinished MM value.
                src_haz[i] = id_src_early[i] & ~mm_wr_ready;
            end else if (hit_wb) begin
                fwd_id_en[i]                    = 1'b1;
                fwd_id_data[i*DATA_W +: DATA_W] = wb_wr_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // EX-stage forwarding. MM data is taken unconditionally: an instruction
    // that reached EX has already been held in ID until its producer was
    // ready, so MM holds final data here.
    // ------------------------------------------------------------------
    always_comb begin
        logic [REG_W-1:0] src;

        fwd_ex_en   = '0;
        fwd_ex_data = '0;
        src         = '0;

        for (int i = 0; i < int'(N_SRC); i++) begin
            src = ex_src_reg[i*REG_W +: REG_W];
            if ((src != '0) && (src == mm_wr_reg)) begin
                fwd_ex_en[i]                    = 1'b1;
                fwd_ex_data[i*DATA_W +: DATA_W] = mm_wr_data;
            end else if ((src != '0) && (src == wb_wr_reg)) begin
                fwd_ex_en[i]                    = 1'b1;
                fwd_ex_data[i*DATA_W +: DATA_W] = wb_wr_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stall. HI/LO readers and new mul/div launches wait while the unit is
    // busy; busy includes count==1, so a back-to-back start waits until the
    // counter has fully drained.
    // ------------------------------------------------------------------
    assign md_busy = (md_cnt_q != '0);
    assign md_haz  = (id_hilo_rd | id_md_start) & md_busy;
    assign stall   = id_valid & ((|src_haz) | md_haz);

    // ------------------------------------------------------------------
    // Mul/div countdown. A zero latency request is treated as one cycle so
    // every accepted launch produces a busy window and a done pulse.
    // ------------------------------------------------------------------
    assign md_load     = id_valid & id_md_start & ~stall;
    assign md_load_val = (id_md_cycles == '0) ? CNT_W'(1) : id_md_cycles;

    always_comb begin
        md_cnt_d  = md_cnt_q;
        md_done_d = 1'b0;
        if (md_cancel) begin
            // Flush wins over everything, including a launch in the same cycle.
            md_cnt_d  = '0;
            md_done_d = 1'b0;
        end else if (md_load) begin
            md_cnt_d = md_load_val;
        end else if (md_busy) begin
            md_cnt_d  = md_cnt_q - CNT_W'(1);
            md_done_d = (md_cnt_q == CNT_W'(1));
        end
    end

    // ------------------------------------------------------------------
    // Stall-cycle performance counter, saturating at all-ones.
    // ------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (perf_clr) begin
            stall_cnt_d = '0;
        end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt_q    <= '0;
            md_done_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            md_done_q   <= md_done_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign md_done      = md_done_q;
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_sb.sv
module tb_fwd_hazard_sb;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int N_SRC  = 2;
    localparam int CNT_W  = 6;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    id_valid;
    logic [N_SRC*REG_W-1:0]  id_src_reg;
    logic [N_SRC-1:0]        id_src_early;
    logic [N_SRC*REG_W-1:0]  ex_src_reg;
    logic [REG_W-1:0]        ex_wr_reg, mm_wr_reg, wb_wr_reg;
    logic [DATA_W-1:0]       ex_wr_data, mm_wr_data, wb_wr_data;
    logic                    ex_wr_ready, mm_wr_ready;
    logic                    id_md_start;
    logic [CNT_W-1:0]        id_md_cycles;
    logic                    id_hilo_rd;
    logic                    md_cancel;
    logic                    perf_clr;
    logic                    stall;
    logic [N_SRC-1:0]        fwd_id_en;
    logic [N_SRC*DATA_W-1:0] fwd_id_data;
    logic [N_SRC-1:0]        fwd_ex_en;
    logic [N_SRC*DATA_W-1:0] fwd_ex_data;
    logic                    md_busy;
    logic                    md_done;
    logic [31:0]             stall_cycles;

    fwd_hazard_sb #(.DATA_W(DATA_W), .REG_W(REG_W), .N_SRC(N_SRC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_src_reg(id_src_reg), .id_src_early(id_src_early),
        .ex_src_reg(ex_src_reg),
        .ex_wr_reg(ex_wr_reg), .mm_wr_reg(mm_wr_reg), .wb_wr_reg(wb_wr_reg),
        .ex_wr_data(ex_wr_data), .mm_wr_data(mm_wr_data), .wb_wr_data(wb_wr_data),
        .ex_wr_ready(ex_wr_ready), .mm_wr_ready(mm_wr_ready),
        .id_md_start(id_md_start), .id_md_cycles(id_md_cycles), .id_hilo_rd(id_hilo_rd),
        .md_cancel(md_cancel), .perf_clr(perf_clr),
        .stall(stall), .fwd_id_en(fwd_id_en), .fwd_id_data(fwd_id_data),
        .fwd_ex_en(fwd_ex_en), .fwd_ex_data(fwd_ex_data),
        .md_busy(md_busy), .md_done(md_done), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Reference state: cycles left on the mul/div unit, pending done pulse, stall count.
    int     m_md_left = 0;
    bit     m_md_done = 1'b0;
    longint m_perf    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        id_valid     = 1'b0;
        id_src_reg   = '0;
        id_src_early = '0;
        ex_src_reg   = '0;
        ex_wr_reg    = '0; mm_wr_reg  = '0; wb_wr_reg  = '0;
        ex_wr_data   = '0; mm_wr_data = '0; wb_wr_data = '0;
        ex_wr_ready  = 1'b1; mm_wr_ready = 1'b1;
        id_md_start  = 1'b0; id_md_cycles = '0; id_hilo_rd = 1'b0;
        md_cancel    = 1'b0; perf_clr = 1'b0;
    endtask

    task automatic model_reset();
        m_md_left = 0;
        m_md_done = 1'b0;
        m_perf    = 0;
    endtask

    // Called just after a falling edge with inputs driven. Checks the
    // combinational outputs, advances the model across the rising edge,
    // checks the registered outputs, and returns at the next falling edge.
    task automatic step();
        logic [REG_W-1:0]        wr  [3];
        logic [DATA_W-1:0]       wd  [3];
        bit                      rdy [3];
        logic [N_SRC-1:0]        e_id_en, e_ex_en;
        logic [N_SRC*DATA_W-1:0] e_id_d, e_ex_d;
        logic [REG_W-1:0]        s;
        bit                      any_haz, e_stall, md_haz;
        int                      nxt_left;
        bit                      nxt_done;

        wr  = '{ex_wr_reg, mm_wr_reg, wb_wr_reg};
        wd  = '{ex_wr_data, mm_wr_data, wb_wr_data};
        rdy = '{ex_wr_ready, mm_wr_ready, 1'b1};
        e_id_en = '0; e_id_d = '0; e_ex_en = '0; e_ex_d = '0;
        any_haz = 1'b0;

        for (int i = 0; i < N_SRC; i++) begin
            s = id_src_reg[i*REG_W +: REG_W];
            if (s != 0) begin
                for (int st = 0; st < 3; st++) begin
                    if (wr[st] == s) begin
                        e_id_en[i] = 1'b1;
                        e_id_d[i*DATA_W +: DATA_W] = wd[st];
                        if (id_src_early[i])
                            any_haz |= (st == 0) || (st == 1 && !rdy[1]);
                        else
                            any_haz |= (st == 0) && !rdy[0];
                        break;
                    end
                end
            end
            s = ex_src_reg[i*REG_W +: REG_W];
            if (s != 0) begin
                for (int st = 1; st < 3; st++) begin
                    if (wr[st] == s) begin
                        e_ex_en[i] = 1'b1;
                        e_ex_d[i*DATA_W +: DATA_W] = wd[st];
                        break;
                    end
                end
            end
        end
        md_haz  = (id_hilo_rd || id_md_start) && (m_md_left != 0);
        e_stall = id_valid && (any_haz || md_haz);

        #1;
        check_eq("stall",       64'(stall),       64'(e_stall));
        check_eq("fwd_id_en",   64'(fwd_id_en),   64'(e_id_en));
        check_eq("fwd_id_data", 64'(fwd_id_data), 64'(e_id_d));
        check_eq("fwd_ex_en",   64'(fwd_ex_en),   64'(e_ex_en));
        check_eq("fwd_ex_data", 64'(fwd_ex_data), 64'(e_ex_d));

        nxt_left = m_md_left;
        nxt_done = 1'b0;
        if (md_cancel) begin
            nxt_left = 0;
        end else if (id_valid && id_md_start && !e_stall) begin
            nxt_left = (id_md_cycles == 0) ? 1 : int'(id_md_cycles);
        end else if (m_md_left > 0) begin
            nxt_left = m_md_left - 1;
            nxt_done = (m_md_left == 1);
        end
        if (perf_clr)
            m_perf = 0;
        else if (e_stall && m_perf < 64'hFFFF_FFFF)
            m_perf = m_perf + 1;
        m_md_left = nxt_left;
        m_md_done = nxt_done;

        @(posedge clk);
        #1;
        check_eq("md_busy",      64'(md_busy),      64'(m_md_left != 0));
        check_eq("md_done",      64'(md_done),      64'(m_md_done));
        check_eq("stall_cycles", 64'(stall_cycles), 64'(m_perf));
        @(negedge clk);
    endtask

    initial begin
        drive_idle();
        rst_n = 1'b0;
        #3;
        check_eq("rst_md_busy", 64'(md_busy),      64'd0);
        check_eq("rst_md_done", 64'(md_done),      64'd0);
        check_eq("rst_perf",    64'(stall_cycles), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step();

        // Normal source, EX result ready: forward, no stall.
        id_valid = 1'b1; id_src_reg[0 +: REG_W] = 5'd5;
        ex_wr_reg = 5'd5; ex_wr_data = 32'h1234; ex_wr_ready = 1'b1;
        #1;
        check_eq("ex_fwd_stall", 64'(stall),               64'd0);
        check_eq("ex_fwd_en0",   64'(fwd_id_en[0]),        64'd1);
        check_eq("ex_fwd_d0",    64'(fwd_id_data[31:0]),   64'h1234);
        step();
        // Load-use.
        ex_wr_ready = 1'b0;
        #1;
        check_eq("load_use_stall", 64'(stall), 64'd1);
        step();

        // Early source against unfinished MM, then finished.
        drive_idle();
        id_valid = 1'b1; id_src_reg[REG_W +: REG_W] = 5'd7; id_src_early = 2'b10;
        mm_wr_reg = 5'd7; mm_wr_ready = 1'b0;
        #1;
        check_eq("early_mm_stall", 64'(stall), 64'd1);
        step();
        mm_wr_ready = 1'b1; mm_wr_data = 32'hBEEF;
        #1;
        check_eq("early_mm_ok",  64'(stall),              64'd0);
        check_eq("early_mm_d1",  64'(fwd_id_data[63:32]), 64'hBEEF);
        step();

        // Priority: all stages write r3.
        drive_idle();
        id_valid = 1'b1;
        ex_wr_reg = 5'd3; mm_wr_reg = 5'd3; wb_wr_reg = 5'd3;
        ex_wr_data = 32'd1; mm_wr_data = 32'd2; wb_wr_data = 32'd3;
        id_src_reg[0 +: REG_W] = 5'd3; ex_src_reg[0 +: REG_W] = 5'd3;
        #1;
        check_eq("prio_id_d0", 64'(fwd_id_data[31:0]), 64'd1);
        check_eq("prio_ex_d0", 64'(fwd_ex_data[31:0]), 64'd2);
        step();
        // r0 never forwards even if a stage reports writing it.
        ex_wr_reg = 5'd0; mm_wr_reg = 5'd0; wb_wr_reg = 5'd0;
        id_src_reg = '0; ex_src_reg = '0; ex_wr_ready = 1'b0;
        #1;
        check_eq("r0_id_en", 64'(fwd_id_en), 64'd0);
        check_eq("r0_ex_en", 64'(fwd_ex_en), 64'd0);
        check_eq("r0_stall", 64'(stall),     64'd0);
        step();

        // Mul/div with 4 cycles, then HI/LO read during busy.
        drive_idle(); perf_clr = 1'b1; step();
        drive_idle(); id_valid = 1'b1; id_md_start = 1'b1; id_md_cycles = 6'd4; step();
        check_eq("md_busy_after_start", 64'(md_busy), 64'd1);
        drive_idle(); id_valid = 1'b1; id_hilo_rd = 1'b1;
        for (int k = 0; k < 5; k++) step();
        check_eq("hilo_stall_count", 64'(stall_cycles), 64'd4);
        drive_idle();
        for (int k = 0; k < 2; k++) step();

        // Cancel two cycles into a countdown of 10.
        id_valid = 1'b1; id_md_start = 1'b1; id_md_cycles = 6'd10; step();
        drive_idle(); step(); step();
        md_cancel = 1'b1; step();
        check_eq("cancel_busy", 64'(md_busy), 64'd0);
        drive_idle();
        for (int k = 0; k < 12; k++) step();
        // Cancel and start together.
        id_valid = 1'b1; id_md_start = 1'b1; id_md_cycles = 6'd5; md_cancel = 1'b1; step();
        check_eq("cancel_start_busy", 64'(md_busy), 64'd0);
        drive_idle(); step();

        // Saturation of the stall counter.
        force dut.stall_cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt_q;
        m_perf = 64'hFFFF_FFFD;
        @(negedge clk);
        id_valid = 1'b1; id_src_reg[0 +: REG_W] = 5'd9; ex_wr_reg = 5'd9; ex_wr_ready = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check_eq("perf_sat", 64'(stall_cycles), 64'hFFFF_FFFF);
        perf_clr = 1'b1; step();
        check_eq("perf_clr", 64'(stall_cycles), 64'd0);

        // Asynchronous reset in the middle of a countdown.
        drive_idle(); id_valid = 1'b1; id_md_start = 1'b1; id_md_cycles = 6'd10; step();
        drive_idle(); step(); step();
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", 64'(md_busy),      64'd0);
        check_eq("arst_done", 64'(md_done),      64'd0);
        check_eq("arst_perf", 64'(stall_cycles), 64'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        step();

        // Randomized traffic against the reference model.
        for (int it = 0; it < 600; it++) begin
            id_valid     = ($urandom_range(0, 99) < 85);
            for (int i = 0; i < N_SRC; i++) begin
                id_src_reg[i*REG_W +: REG_W] = REG_W'($urandom_range(0, 3));
                ex_src_reg[i*REG_W +: REG_W] = REG_W'($urandom_range(0, 3));
            end
            id_src_early = N_SRC'($urandom_range(0, 3));
            ex_wr_reg    = REG_W'($urandom_range(0, 3));
            mm_wr_reg    = REG_W'($urandom_range(0, 3));
            wb_wr_reg    = REG_W'($urandom_range(0, 3));
            ex_wr_data   = $urandom;
            mm_wr_data   = $urandom;
            wb_wr_data   = $urandom;
            ex_wr_ready  = ($urandom_range(0, 1) == 1);
            mm_wr_ready  = ($urandom_range(0, 1) == 1);
            id_md_start  = ($urandom_range(0, 99) < 15);
            id_md_cycles = CNT_W'($urandom_range(0, 7));
            id_hilo_rd   = ($urandom_range(0, 99) < 20);
            md_cancel    = ($urandom_range(0, 99) < 3);
            perf_clr     = ($urandom_range(0, 99) < 2);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
